// File: rtl/m_rep_upload_mq.sv
// Memory-side reply uploader: queues up to two whole reply messages and streams them as head/body/tail flits.
// Optional statistics counters are enabled by defining M_REP_UPLOAD_STAT_EN.
module m_rep_upload_mq #(
  parameter int FLIT_W    = 16,
  parameter int MAX_FLITS = 11,
  parameter int CNT_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef M_REP_UPLOAD_STAT_EN
  output logic [15:0]                 m_rep_msg_cnt,
  output logic [15:0]                 m_rep_flit_cnt,
`endif
  input  logic [FLIT_W*MAX_FLITS-1:0] m_flits_rep,
  input  logic                        v_m_flits_rep,
  input  logic [CNT_W-1:0]            flits_max,
  input  logic                        en_flits_max,
  input  logic                        rep_fifo_rdy,
  output logic [FLIT_W-1:0]           m_flit_out,
  output logic                        v_m_flit_out,
  output logic [1:0]                  m_ctrl_out,
  output logic                        m_rep_upload_state,
  output logic                        m_rep_upload_rdy,
  output logic                        m_rep_upload_ovf
);

  localparam int MSG_W = FLIT_W * MAX_FLITS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_FLITS - 1);

  logic [MSG_W-1:0] mem_q [2];
  logic [CNT_W-1:0] memLen_q [2];
  logic             wrPtr_q, wrPtr_d;
  logic             rdPtr_q, rdPtr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic             headValid;
  logic [MSG_W-1:0] headMsg;
  logic [CNT_W-1:0] headLen;
  logic [CNT_W-1:0] clampedLen;
  logic [CNT_W-1:0] captureLen;
  logic             accept;
  logic             xfer;
  logic             lastXfer;
  logic [FLIT_W-1:0] flitSel;

  always_comb begin
    headValid  = (count_q != 2'd0);
    headMsg    = mem_q[rdPtr_q];
    headLen    = memLen_q[rdPtr_q];
    clampedLen = (flits_max > LAST_IDX) ? LAST_IDX : flits_max;
    // A length written in the same cycle as a message applies to that message.
    captureLen = en_flits_max ? clampedLen : len_q;
    accept     = v_m_flits_rep && (count_q != 2'd2);
    xfer       = headValid && rep_fifo_rdy;
    lastXfer   = xfer && (idx_q == headLen);
  end

  always_comb begin
    flitSel = '0;
    for (int k = 0; k < MAX_FLITS; k++) begin
      if (idx_q == CNT_W'(k)) flitSel = headMsg[MSG_W-1-FLIT_W*k -: FLIT_W];
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    idx_d   = idx_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    if (en_flits_max) len_d = clampedLen;
    if (v_m_flits_rep && !accept) ovf_d = 1'b1;
    if (accept) wrPtr_d = ~wrPtr_q;
    if (xfer) begin
      if (lastXfer) begin
        idx_d   = '0;
        rdPtr_d = ~rdPtr_q;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    // Accept and pop in the same cycle leave the occupancy unchanged.
    case ({accept, lastXfer})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
      idx_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i]    <= '0;
        memLen_q[i] <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      if (accept) begin
        mem_q[wrPtr_q]    <= m_flits_rep;
        memLen_q[wrPtr_q] <= captureLen;
      end
    end
  end

`ifdef M_REP_UPLOAD_STAT_EN
  logic [15:0] msgCnt_q, msgCnt_d;
  logic [15:0] flitCnt_q, flitCnt_d;

  always_comb begin
    msgCnt_d  = lastXfer ? msgCnt_q + 16'd1 : msgCnt_q;
    flitCnt_d = xfer ? flitCnt_q + 16'd1 : flitCnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msgCnt_q  <= '0;
      flitCnt_q <= '0;
    end else begin
      msgCnt_q  <= msgCnt_d;
      flitCnt_q <= flitCnt_d;
    end
  end

  assign m_rep_msg_cnt  = msgCnt_q;
  assign m_rep_flit_cnt = flitCnt_q;
`endif

  assign v_m_flit_out       = headValid;
  assign m_flit_out         = headValid ? flitSel : '0;
  assign m_ctrl_out         = !headValid          ? 2'b00 :
                              (idx_q == headLen)  ? 2'b11 :
                              (idx_q == '0)       ? 2'b01 : 2'b10;
  assign m_rep_upload_state = headValid;
  assign m_rep_upload_rdy   = (count_q != 2'd2);
  assign m_rep_upload_ovf   = ovf_q;

endmodule

// File: tb/tb_m_rep_upload_mq.sv
// Directed self-checking bench for m_rep_upload_mq: single flit, stall, back-to-back, overflow, clamp and async reset.
module tb_m_rep_upload_mq;

  localparam int FLIT_W    = 16;
  localparam int MAX_FLITS = 11;
  localparam int CNT_W     = 4;
  localparam int MSG_W     = FLIT_W * MAX_FLITS;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [MSG_W-1:0]  m_flits_rep = '0;
  logic              v_m_flits_rep = 1'b0;
  logic [CNT_W-1:0]  flits_max = '0;
  logic              en_flits_max = 1'b0;
  logic              rep_fifo_rdy = 1'b0;
  logic [FLIT_W-1:0] m_flit_out;
  logic              v_m_flit_out;
  logic [1:0]        m_ctrl_out;
  logic              m_rep_upload_state;
  logic              m_rep_upload_rdy;
  logic              m_rep_upload_ovf;
`ifdef M_REP_UPLOAD_STAT_EN
  logic [15:0]       m_rep_msg_cnt;
  logic [15:0]       m_rep_flit_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [FLIT_W-1:0] seqFlits [MAX_FLITS];
  logic [MSG_W-1:0]  seqMsg;

  m_rep_upload_mq #(.FLIT_W(FLIT_W), .MAX_FLITS(MAX_FLITS), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst                (rst),
`ifdef M_REP_UPLOAD_STAT_EN
    .m_rep_msg_cnt      (m_rep_msg_cnt),
    .m_rep_flit_cnt     (m_rep_flit_cnt),
`endif
    .m_flits_rep        (m_flits_rep),
    .v_m_flits_rep      (v_m_flits_rep),
    .flits_max          (flits_max),
    .en_flits_max       (en_flits_max),
    .rep_fifo_rdy       (rep_fifo_rdy),
    .m_flit_out         (m_flit_out),
    .v_m_flit_out       (v_m_flit_out),
    .m_ctrl_out         (m_ctrl_out),
    .m_rep_upload_state (m_rep_upload_state),
    .m_rep_upload_rdy   (m_rep_upload_rdy),
    .m_rep_upload_ovf   (m_rep_upload_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [MSG_W-1:0] msg,
                               input logic [CNT_W-1:0] fm, input logic en, input logic frdy);
    v_m_flits_rep = v;
    m_flits_rep   = msg;
    flits_max     = fm;
    en_flits_max  = en;
    rep_fifo_rdy  = frdy;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic expV, input logic [1:0] expCtrl,
                             input logic [FLIT_W-1:0] expFlit, input logic expState, input logic expRdy);
    checkVal($sformatf("%s.v", tag), 32'(v_m_flit_out), 32'(expV));
    checkVal($sformatf("%s.ctrl", tag), 32'(m_ctrl_out), 32'(expCtrl));
    checkVal($sformatf("%s.flit", tag), 32'(m_flit_out), 32'(expFlit));
    checkVal($sformatf("%s.state", tag), 32'(m_rep_upload_state), 32'(expState));
    checkVal($sformatf("%s.rdy", tag), 32'(m_rep_upload_rdy), 32'(expRdy));
  endtask

  initial begin
    seqFlits = '{16'h0123, 16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678,
                 16'h6789, 16'h7890, 16'h8901, 16'h9012, 16'h0a12};
    seqMsg = '0;
    for (int k = 0; k < MAX_FLITS; k++) seqMsg[MSG_W-1-FLIT_W*k -: FLIT_W] = seqFlits[k];

    // Reset state
    #12;
    checkOutput("reset", 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1);
    checkVal("reset.ovf", 32'(m_rep_upload_ovf), 32'd0);
    rst = 1'b1;
    tick();

    // Single flit message
    applyStimulus(1'b1, {16'hc0de, 16'hc1de, 144'h0}, 4'd0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b1);
    checkOutput("single", 1'b1, 2'b11, 16'hc0de, 1'b1, 1'b1);
    tick();
    checkOutput("single.done", 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1);

    // Three flits with a stall after the head
    applyStimulus(1'b1, {16'habc1, 16'habc2, 16'habc3, 128'h0}, 4'd2, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b1);
    checkOutput("stall.f0", 1'b1, 2'b01, 16'habc1, 1'b1, 1'b1);
    tick();
    checkOutput("stall.f1", 1'b1, 2'b10, 16'habc2, 1'b1, 1'b1);
    rep_fifo_rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      checkOutput($sformatf("stall.hold%0d", s), 1'b1, 2'b10, 16'habc2, 1'b1, 1'b1);
    end
    rep_fifo_rdy = 1'b1;
    tick();
    checkOutput("stall.f2", 1'b1, 2'b11, 16'habc3, 1'b1, 1'b1);
    tick();
    checkOutput("stall.done", 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1);

    // Back-to-back two-flit messages
    applyStimulus(1'b1, {16'ha001, 16'ha002, 144'h0}, 4'd1, 1'b1, 1'b1);
    tick();
    checkOutput("b2b.a0", 1'b1, 2'b01, 16'ha001, 1'b1, 1'b1);
    applyStimulus(1'b1, {16'hb001, 16'hb002, 144'h0}, 4'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b1);
    checkOutput("b2b.a1", 1'b1, 2'b11, 16'ha002, 1'b1, 1'b0);
    tick();
    checkOutput("b2b.b0", 1'b1, 2'b01, 16'hb001, 1'b1, 1'b1);
    tick();
    checkOutput("b2b.b1", 1'b1, 2'b11, 16'hb002, 1'b1, 1'b1);
    tick();
    checkOutput("b2b.done", 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1);
    checkVal("b2b.ovf", 32'(m_rep_upload_ovf), 32'd0);

    // Overflow: fill both entries while the FIFO is blocked, then offer a third
    applyStimulus(1'b1, {16'hc001, 16'hc002, 144'h0}, 4'd1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, {16'hd001, 16'hd002, 144'h0}, 4'd0, 1'b0, 1'b0);
    tick();
    checkOutput("ovf.full", 1'b1, 2'b01, 16'hc001, 1'b1, 1'b0);
    checkVal("ovf.pre", 32'(m_rep_upload_ovf), 32'd0);
    applyStimulus(1'b1, {16'he001, 16'he002, 144'h0}, 4'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b1);
    checkOutput("ovf.drop", 1'b1, 2'b01, 16'hc001, 1'b1, 1'b0);
    checkVal("ovf.set", 32'(m_rep_upload_ovf), 32'd1);
    tick();
    checkOutput("ovf.c1", 1'b1, 2'b11, 16'hc002, 1'b1, 1'b0);
    tick();
    checkOutput("ovf.d0", 1'b1, 2'b01, 16'hd001, 1'b1, 1'b1);
    tick();
    checkOutput("ovf.d1", 1'b1, 2'b11, 16'hd002, 1'b1, 1'b1);
    tick();
    checkOutput("ovf.done", 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1);
    checkVal("ovf.sticky", 32'(m_rep_upload_ovf), 32'd1);

    // Clamp of flits_max=F to the maximum, loaded with the message
    applyStimulus(1'b1, seqMsg, 4'hF, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b1);
    for (int k = 0; k < MAX_FLITS; k++) begin
      checkOutput($sformatf("clamp.f%0d", k), 1'b1,
                  (k == 0) ? 2'b01 : (k == MAX_FLITS - 1) ? 2'b11 : 2'b10,
                  seqFlits[k], 1'b1, 1'b1);
      tick();
    end
    checkOutput("clamp.done", 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1);
`ifdef M_REP_UPLOAD_STAT_EN
    checkVal("stat.msgs", 32'(m_rep_msg_cnt), 32'd7);
    checkVal("stat.flits", 32'(m_rep_flit_cnt), 32'd23);
`endif

    // Async reset in the middle of a nine-flit message
    applyStimulus(1'b1, seqMsg, 4'd8, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    checkOutput("rstmid.f4", 1'b1, 2'b10, 16'h4567, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rstmid.async", 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1);
    checkVal("rstmid.ovf", 32'(m_rep_upload_ovf), 32'd0);
`ifdef M_REP_UPLOAD_STAT_EN
    checkVal("rstmid.msgs", 32'(m_rep_msg_cnt), 32'd0);
    checkVal("rstmid.flits", 32'(m_rep_flit_cnt), 32'd0);
`endif
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("rstmid.idle%0d", k), 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
